// File: rtl/bandai2003_bank_sequencer.sv
// Host-side unlock handshake and bank-register (C0h-C3h) bus sequencer for the BANDAI2003 mapper.
// Define SO_CHECK_EN to verify the SO unlock signature and trap mismatches in an error state.
module bandai2003_bank_sequencer #(
  parameter int WR_CYC = 2,
  parameter int RD_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_RD,
  input  logic [1:0]  CMD_SEL,
  input  logic [7:0]  CMD_DATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_DATA,
  output logic        UNLOCKED,
  output logic        ERR,
  output logic [31:0] SHADOW,
  input  logic        SO,
  output logic        CEn,
  output logic        WEn,
  output logic        OEn,
  output logic        SSn,
  output logic [7:0]  ADDR,
  output logic [7:0]  DQ_O,
  input  logic [7:0]  DQ_I,
  output logic        DQ_OE
);

  localparam logic [17:0] SO_SIG = 18'h05140;
  localparam int SO_LEN  = 18;
  localparam int CNT_MAX = (WR_CYC > RD_CYC) ? ((WR_CYC > SO_LEN) ? WR_CYC : SO_LEN)
                                             : ((RD_CYC > SO_LEN) ? RD_CYC : SO_LEN);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SO_LAST = CNT_W'(SO_LEN - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [7:0] ADDR_IDLE = 8'hFF;

  typedef enum logic [3:0] {RST_S, ACK, NAK, SO_CHK, IDLE, WR, WH, RD, ERRS} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cen_reg, wen_reg, oen_reg, dq_oe_reg;
  logic [7:0]       addr_reg, dq_o_reg;
  logic             ready_reg, rsp_valid_reg, unlocked_reg;
  logic [7:0]       rsp_data_reg;
  logic [1:0]       sel_reg;
  logic [7:0]       shadow_reg [4];

`ifdef SO_CHECK_EN
  logic err_reg;
  logic so_exp;
  logic so_miss;
  assign so_exp  = SO_SIG[cnt_reg[4:0]];
  assign so_miss = (SO != so_exp);
  assign ERR     = err_reg;
`else
  logic unused_so;
  assign unused_so = SO;
  assign ERR       = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= RST_S;
      cnt_reg       <= '0;
      cen_reg       <= 1'b1;
      wen_reg       <= 1'b1;
      oen_reg       <= 1'b1;
      dq_oe_reg     <= 1'b0;
      addr_reg      <= ADDR_IDLE;
      dq_o_reg      <= 8'h00;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      unlocked_reg  <= 1'b0;
      sel_reg       <= 2'd0;
      for (int i = 0; i < 4; i++) shadow_reg[i] <= 8'hFF;
`ifdef SO_CHECK_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        RST_S: begin
          state_reg <= ACK;
          addr_reg  <= 8'h5A;
        end
        ACK: begin
          state_reg <= NAK;
          addr_reg  <= 8'hA5;
        end
        // The mapper loads its signature shift register on the edge leaving NAK.
        NAK: begin
          state_reg <= SO_CHK;
          addr_reg  <= ADDR_IDLE;
          cnt_reg   <= '0;
        end
        SO_CHK: begin
`ifdef SO_CHECK_EN
          if (so_miss) err_reg <= 1'b1;
          if (cnt_reg == SO_LAST) begin
            if (err_reg || so_miss) begin
              state_reg <= ERRS;
            end else begin
              state_reg    <= IDLE;
              unlocked_reg <= 1'b1;
              ready_reg    <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`else
          if (cnt_reg == SO_LAST) begin
            state_reg    <= IDLE;
            unlocked_reg <= 1'b1;
            ready_reg    <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        IDLE: begin
          if (CMD_VALID) begin
            ready_reg <= 1'b0;
            sel_reg   <= CMD_SEL;
            addr_reg  <= {6'b110000, CMD_SEL};
            cen_reg   <= 1'b0;
            cnt_reg   <= '0;
            if (CMD_RD) begin
              state_reg <= RD;
              oen_reg   <= 1'b0;
            end else begin
              state_reg <= WR;
              wen_reg   <= 1'b0;
              dq_oe_reg <= 1'b1;
              dq_o_reg  <= CMD_DATA;
            end
          end
        end
        WR: begin
          if (cnt_reg == WR_LAST) begin
            state_reg           <= WH;
            wen_reg             <= 1'b1;
            shadow_reg[sel_reg] <= dq_o_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        // Data and chip enable stay valid one cycle past the WEn rise for hold time.
        WH: begin
          state_reg <= IDLE;
          cen_reg   <= 1'b1;
          dq_oe_reg <= 1'b0;
          addr_reg  <= ADDR_IDLE;
          ready_reg <= 1'b1;
        end
        RD: begin
          if (cnt_reg == RD_LAST) begin
            state_reg     <= IDLE;
            oen_reg       <= 1'b1;
            cen_reg       <= 1'b1;
            addr_reg      <= ADDR_IDLE;
            rsp_data_reg  <= DQ_I;
            rsp_valid_reg <= 1'b1;
            ready_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ERRS: begin
          ready_reg <= 1'b0;
        end
        default: begin
          state_reg <= RST_S;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
    assign SHADOW[gi*8 +: 8] = shadow_reg[gi];
  end

  assign CMD_READY = ready_reg;
  assign RSP_VALID = rsp_valid_reg;
  assign RSP_DATA  = rsp_data_reg;
  assign UNLOCKED  = unlocked_reg;
  assign CEn       = cen_reg;
  assign WEn       = wen_reg;
  assign OEn       = oen_reg;
  assign SSn       = 1'b1;
  assign ADDR      = addr_reg;
  assign DQ_O      = dq_o_reg;
  assign DQ_OE     = dq_oe_reg;

endmodule

// File: tb/tb_bandai2003_bank_sequencer.sv
// Self-checking bench for bandai2003_bank_sequencer with a behavioural BANDAI2003 mapper model.
// Honours SO_CHECK_EN when deciding the expected outcome of a corrupted unlock signature.
module tb_bandai2003_bank_sequencer;
  localparam int WR_CYC = 2;
  localparam int RD_CYC = 2;
`ifdef SO_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam logic [17:0] SO_SIG = 18'h05140;

  logic        CLK, RST, CMD_VALID, CMD_READY, CMD_RD;
  logic [1:0]  CMD_SEL;
  logic [7:0]  CMD_DATA, RSP_DATA, ADDR, DQ_O, DQ_I;
  logic        RSP_VALID, UNLOCKED, ERR, SO, CEn, WEn, OEn, SSn, DQ_OE;
  logic [31:0] SHADOW;

  int checks = 0;
  int failures = 0;

  // Mapper model: signature shifter loaded on A5h, registers latched on WEn rise with CEn low.
  logic [7:0]  map_reg [4] = '{default: 8'hFF};
  logic [17:0] sreg = '0;
  logic        wen_q = 1'b1;
  bit          corrupt = 1'b0;

  // Bench-side expectations.
  logic [7:0] exp_map [4] = '{default: 8'hFF};
  logic [7:0] exp_sh  [4] = '{default: 8'hFF};

  bandai2003_bank_sequencer #(.WR_CYC(WR_CYC), .RD_CYC(RD_CYC)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RD(CMD_RD),
    .CMD_SEL(CMD_SEL), .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .UNLOCKED(UNLOCKED), .ERR(ERR), .SHADOW(SHADOW), .SO(SO), .CEn(CEn), .WEn(WEn),
    .OEn(OEn), .SSn(SSn), .ADDR(ADDR), .DQ_O(DQ_O), .DQ_I(DQ_I), .DQ_OE(DQ_OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign SO   = sreg[0];
  assign DQ_I = (!CEn && !OEn && ADDR[7:2] == 6'b110000) ? map_reg[ADDR[1:0]] : 8'h00;

  always @(posedge CLK) begin
    wen_q <= WEn;
    if (ADDR == 8'hA5) sreg <= corrupt ? (SO_SIG ^ 18'h00040) : SO_SIG;
    else               sreg <= {1'b0, sreg[17:1]};
    if (!wen_q && WEn && !CEn && ADDR[7:2] == 6'b110000) map_reg[ADDR[1:0]] <= DQ_O;
  end

  function automatic logic [31:0] exp_word();
    return {exp_sh[3], exp_sh[2], exp_sh[1], exp_sh[0]};
  endfunction

  task automatic reset_and_unlock();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 4; i++) exp_sh[i] = 8'hFF;
    repeat (21) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [7:0] a1, a2;
    int unl_bad;
    a1 = 8'h00; a2 = 8'h00; unl_bad = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({CEn, WEn, OEn, SSn} !== 4'b1111 || ADDR !== 8'hFF || DQ_OE !== 1'b0 || DQ_O !== 8'h00 ||
        CMD_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_DATA !== 8'h00 || UNLOCKED !== 1'b0 ||
        ERR !== 1'b0 || SHADOW !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL reset_state: got strobes=%b addr=%h oe=%b dq=%h rdy=%b rv=%b rd=%h unl=%b err=%b sh=%h, want 1111 ff 0 00 0 0 00 0 0 ffffffff",
               {CEn, WEn, OEn, SSn}, ADDR, DQ_OE, DQ_O, CMD_READY, RSP_VALID, RSP_DATA, UNLOCKED, ERR, SHADOW);
    end
    RST = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      if (k == 1) a1 = ADDR;
      if (k == 2) a2 = ADDR;
      if (UNLOCKED !== (k >= 21)) unl_bad++;
    end
    checks++;
    if (a1 !== 8'h5A || a2 !== 8'hA5) begin
      failures++; $display("FAIL unlock_addr: got %h,%h want 5a,a5", a1, a2);
    end
    checks++;
    if (unl_bad != 0) begin
      failures++; $display("FAIL unlock_timing: %0d cycles with wrong UNLOCKED, want 0 (rise at cycle 21)", unl_bad);
    end
    checks++;
    if (ERR !== 1'b0 || CMD_READY !== 1'b1) begin
      failures++; $display("FAIL unlock_idle: err=%b rdy=%b want 0 1", ERR, CMD_READY);
    end
    $display("test_reset done: addr %h,%h unlocked=%b", a1, a2, UNLOCKED);
  endtask

  task automatic test_write();
    int wen_low, cen_low, bus_bad, wen_rise_k;
    wen_low = 0; cen_low = 0; bus_bad = 0; wen_rise_k = 0;
    checks++;
    if (CMD_READY !== 1'b1) begin failures++; $display("FAIL write_ready: got %b want 1", CMD_READY); end
    CMD_RD = 1'b0; CMD_SEL = 2'd2; CMD_DATA = 8'h3C; CMD_VALID = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) CMD_VALID = 1'b0;
      if (WEn === 1'b0) wen_low++;
      if (WEn === 1'b1 && wen_low > 0 && wen_rise_k == 0) wen_rise_k = k;
      if (CEn === 1'b0) begin
        cen_low++;
        if (DQ_OE !== 1'b1 || ADDR !== 8'hC2 || DQ_O !== 8'h3C) bus_bad++;
      end
    end
    exp_map[2] = 8'h3C; exp_sh[2] = 8'h3C;
    checks++;
    if (wen_low != WR_CYC || wen_rise_k != WR_CYC + 1) begin
      failures++; $display("FAIL write_wen: low=%0d rise_k=%0d want %0d %0d", wen_low, wen_rise_k, WR_CYC, WR_CYC + 1);
    end
    checks++;
    if (cen_low != WR_CYC + 1 || bus_bad != 0) begin
      failures++; $display("FAIL write_cen: low=%0d bad=%0d want %0d 0", cen_low, bus_bad, WR_CYC + 1);
    end
    checks++;
    if (map_reg[2] !== 8'h3C || SHADOW[23:16] !== 8'h3C) begin
      failures++; $display("FAIL write_data: model=%h shadow=%h want 3c 3c", map_reg[2], SHADOW[23:16]);
    end
    checks++;
    if (CMD_READY !== 1'b1 || ADDR !== 8'hFF || DQ_OE !== 1'b0) begin
      failures++; $display("FAIL write_idle: rdy=%b addr=%h oe=%b want 1 ff 0", CMD_READY, ADDR, DQ_OE);
    end
    $display("test_write sel=2 data=3c wen_low=%0d cen_low=%0d shadow=%h", wen_low, cen_low, SHADOW);
  endtask

  task automatic test_read();
    int rv_k, rv_n, oe_hi, oen_low;
    logic [7:0] rdata;
    rv_k = 0; rv_n = 0; oe_hi = 0; oen_low = 0; rdata = 8'h00;
    CMD_RD = 1'b1; CMD_SEL = 2'd0; CMD_VALID = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) CMD_VALID = 1'b0;
      if (DQ_OE !== 1'b0) oe_hi++;
      if (OEn === 1'b0) oen_low++;
      if (RSP_VALID === 1'b1) begin rv_n++; rv_k = k; rdata = RSP_DATA; end
    end
    checks++;
    if (rv_k != RD_CYC + 1 || rv_n != 1) begin
      failures++; $display("FAIL read_latency: pulse at %0d count %0d want %0d 1", rv_k, rv_n, RD_CYC + 1);
    end
    checks++;
    if (rdata !== exp_map[0]) begin failures++; $display("FAIL read_data: got %h want %h", rdata, exp_map[0]); end
    checks++;
    if (oe_hi != 0 || oen_low != RD_CYC) begin
      failures++; $display("FAIL read_pins: dq_oe_high=%0d oen_low=%0d want 0 %0d", oe_hi, oen_low, RD_CYC);
    end
    $display("test_read sel=0 data=%h at cycle %0d", rdata, rv_k);
  endtask

  task automatic test_back_to_back();
    int kw, kr, rv_k;
    logic prev_cen;
    logic [7:0] rdata;
    kw = 0; kr = 0; rv_k = 0; prev_cen = 1'b1; rdata = 8'h00;
    @(negedge CLK);
    RST = 1'b1; CMD_VALID = 1'b1; CMD_RD = 1'b0; CMD_SEL = 2'd1; CMD_DATA = 8'h81;
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 4; i++) exp_sh[i] = 8'hFF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (CEn === 1'b0 && prev_cen === 1'b1) begin
        if (kw == 0) begin kw = k; CMD_RD = 1'b1; end
        else if (kr == 0) begin kr = k; CMD_VALID = 1'b0; end
      end
      prev_cen = CEn;
      if (RSP_VALID === 1'b1 && rv_k == 0) begin rv_k = k; rdata = RSP_DATA; end
    end
    CMD_VALID = 1'b0;
    exp_map[1] = 8'h81; exp_sh[1] = 8'h81;
    checks++;
    if (kw != 22) begin failures++; $display("FAIL held_accept: accepted at %0d want 22", kw); end
    checks++;
    if (kr != kw + WR_CYC + 2 || rv_k != kr + RD_CYC) begin
      failures++; $display("FAIL b2b_timing: read acc=%0d rsp=%0d want %0d %0d", kr, rv_k, kw + WR_CYC + 2, kw + WR_CYC + 2 + RD_CYC);
    end
    checks++;
    if (rdata !== 8'h81 || map_reg[1] !== 8'h81 || SHADOW !== exp_word()) begin
      failures++; $display("FAIL b2b_data: rsp=%h model=%h sh=%h want 81 81 %h", rdata, map_reg[1], SHADOW, exp_word());
    end
    $display("test_back_to_back write@%0d read@%0d rsp@%0d data=%h", kw, kr, rv_k, rdata);
  endtask

  task automatic test_so_error();
    int rdy_bad, unl_k, exp_unl_k;
    logic exp_err;
    rdy_bad = 0; unl_k = 0;
    exp_unl_k = CHK_EN ? 0 : 21;
    exp_err = CHK_EN;
    corrupt = 1'b1;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 4; i++) exp_sh[i] = 8'hFF;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (CMD_READY !== (!CHK_EN && k >= 21)) rdy_bad++;
      if (UNLOCKED === 1'b1 && unl_k == 0) unl_k = k;
    end
    checks++;
    if (ERR !== exp_err) begin failures++; $display("FAIL so_err: got %b want %b", ERR, exp_err); end
    checks++;
    if (unl_k != exp_unl_k) begin failures++; $display("FAIL so_unlock: rise at %0d want %0d", unl_k, exp_unl_k); end
    checks++;
    if (rdy_bad != 0) begin failures++; $display("FAIL so_ready: %0d wrong cycles want 0", rdy_bad); end
    corrupt = 1'b0;
    $display("test_so_error err=%b unlocked_at=%0d", ERR, unl_k);
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] data, a1, a2;
    logic unl;
    data = 8'($urandom_range(0, 254)); a1 = 8'h00; a2 = 8'h00; unl = 1'b0;
    reset_and_unlock();
    CMD_RD = 1'b0; CMD_SEL = 2'd3; CMD_DATA = data; CMD_VALID = 1'b1;
    @(negedge CLK); CMD_VALID = 1'b0;
    checks++;
    if (WEn !== 1'b0) begin failures++; $display("FAIL abort_pre: WEn=%b want 0", WEn); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) exp_sh[i] = 8'hFF;
    checks++;
    if (WEn !== 1'b1 || CEn !== 1'b1 || DQ_OE !== 1'b0 || ADDR !== 8'hFF || SHADOW !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL abort_pins: wen=%b cen=%b oe=%b addr=%h sh=%h want 1 1 0 ff ffffffff", WEn, CEn, DQ_OE, ADDR, SHADOW);
    end
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      if (k == 1) a1 = ADDR;
      if (k == 2) a2 = ADDR;
      if (k == 21) unl = UNLOCKED;
    end
    checks++;
    if (map_reg[3] !== exp_map[3]) begin failures++; $display("FAIL abort_model: reg=%h want %h", map_reg[3], exp_map[3]); end
    checks++;
    if (a1 !== 8'h5A || a2 !== 8'hA5 || unl !== 1'b1) begin
      failures++; $display("FAIL abort_relock: addr %h,%h unl=%b want 5a,a5 1", a1, a2, unl);
    end
    $display("test_reset_mid_write data=%h model=%h relocked=%b", data, map_reg[3], unl);
  endtask

  task automatic test_random();
    logic rd;
    logic [1:0] sel;
    logic [7:0] data, rdata;
    int t, len, inv_bad, rv_n;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1)); sel = 2'($urandom_range(0, 3)); data = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      t = 0;
      while (CMD_READY !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
      checks++;
      if (CMD_READY !== 1'b1) begin failures++; $display("FAIL rand_ready[%0d]: got %b want 1", n, CMD_READY); end
      CMD_RD = rd; CMD_SEL = sel; CMD_DATA = data; CMD_VALID = 1'b1;
      len = rd ? RD_CYC + 1 : WR_CYC + 2;
      inv_bad = 0; rv_n = 0; rdata = 8'h00;
      for (int k = 1; k <= len; k++) begin
        @(negedge CLK);
        if (k == 1) CMD_VALID = 1'b0;
        if ((WEn === 1'b0 && OEn === 1'b0) || SSn !== 1'b1 || (OEn === 1'b0 && DQ_OE !== 1'b0)) inv_bad++;
        if (RSP_VALID === 1'b1) begin rv_n++; rdata = RSP_DATA; end
      end
      if (!rd) begin exp_map[sel] = data; exp_sh[sel] = data; end
      checks++;
      if (inv_bad != 0) begin failures++; $display("FAIL rand_pins[%0d]: %0d bad cycles want 0", n, inv_bad); end
      if (rd) begin
        checks++;
        if (rv_n != 1 || rdata !== exp_map[sel]) begin
          failures++; $display("FAIL rand_read[%0d]: sel=%0d pulses=%0d data=%h want 1 %h", n, sel, rv_n, rdata, exp_map[sel]);
        end
      end
      checks++;
      if (SHADOW !== exp_word() || map_reg[sel] !== exp_map[sel] || CMD_READY !== 1'b1) begin
        failures++; $display("FAIL rand_state[%0d]: sh=%h model=%h rdy=%b want %h %h 1", n, SHADOW, map_reg[sel], CMD_READY, exp_word(), exp_map[sel]);
      end
      $display("rand[%0d] %s sel=%0d data=%h rsp=%h shadow=%h", n, rd ? "RD" : "WR", sel, rd ? rdata : data, rdata, SHADOW);
    end
  endtask

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_RD = 1'b0; CMD_SEL = 2'd0; CMD_DATA = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_so_error();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
